// File: rtl/fx2_slave_fifo_if.sv
// FX2 slave-FIFO strobe, address and flag signals between the FPGA master
// logic and the FX2-side model. The 16-bit data bus is bidirectional and is
// carried as a plain inout port next to this interface.
interface fx2_slave_fifo_if;
    logic [1:0] addr;
    logic       slrd;
    logic       slwr;
    logic       sloe;
    logic       flag_ef;
    logic       flag_ff;

    modport master (output addr, slrd, slwr, sloe, input  flag_ef, flag_ff);
    modport slave  (input  addr, slrd, slwr, sloe, output flag_ef, flag_ff);
endinterface

// File: rtl/fx2_slave_fifo.sv
// FX2 side of the 16-bit synchronous slave-FIFO interface.
// EP2 (OUT): host pushes, FPGA drains with slrd and reads the head on data.
// EP6 (IN):  FPGA fills with slwr from data, host pops.
// Optional protocol error counter enabled by defining FX2_SLFIFO_ERRCNT_EN;
// without it err_count is tied to zero.
module fx2_slave_fifo #(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
    input  logic            clk,
    input  logic            clk_locked,
    inout  wire  [15:0]     data,
    fx2_slave_fifo_if.slave bus,
    input  logic [15:0]     host_wr_data,
    input  logic            host_wr_valid,
    output logic            host_wr_ready,
    output logic [15:0]     host_rd_data,
    output logic            host_rd_valid,
    input  logic            host_rd_ready,
    output logic [7:0]      err_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    logic [15:0] ep2_mem [DEPTH];
    logic [15:0] ep6_mem [DEPTH];

    ptr_t        ep2_wp, ep2_rp, ep6_wp, ep6_rp;
    cnt_t        ep2_cnt, ep6_cnt, ep2_cnt_nxt, ep6_cnt_nxt;
    logic        ep2_push, ep2_pop, ep6_push, ep6_pop;
    logic        ep2_empty, ep2_full, ep6_empty, ep6_full;
    logic        data_oe;
    logic [15:0] data_out;

    // Legality of each FIFO operation is judged against the pre-edge count,
    // so a push and pop in the same cycle leave the count unchanged.
    always_comb begin
        ep2_empty   = (ep2_cnt == '0);
        ep2_full    = (ep2_cnt == CNT_FULL);
        ep6_empty   = (ep6_cnt == '0);
        ep6_full    = (ep6_cnt == CNT_FULL);
        ep2_push    = host_wr_valid && !ep2_full;
        ep2_pop     = !bus.slrd && (bus.addr == 2'b00) && !ep2_empty;
        ep6_push    = !bus.slwr && (bus.addr == 2'b10) && !ep6_full;
        ep6_pop     = host_rd_ready && !ep6_empty;
        ep2_cnt_nxt = ep2_cnt;
        ep6_cnt_nxt = ep6_cnt;
        if (ep2_push && !ep2_pop)      ep2_cnt_nxt = ep2_cnt + 1'b1;
        else if (!ep2_push && ep2_pop) ep2_cnt_nxt = ep2_cnt - 1'b1;
        if (ep6_push && !ep6_pop)      ep6_cnt_nxt = ep6_cnt + 1'b1;
        else if (!ep6_push && ep6_pop) ep6_cnt_nxt = ep6_cnt - 1'b1;
    end

    // Pointers, counts and flags; flags follow the post-edge count.
    always_ff @(posedge clk) begin
        if (!clk_locked) begin
            ep2_wp      <= '0;
            ep2_rp      <= '0;
            ep6_wp      <= '0;
            ep6_rp      <= '0;
            ep2_cnt     <= '0;
            ep6_cnt     <= '0;
            bus.flag_ef <= 1'b0;
            bus.flag_ff <= 1'b1;
        end else begin
            if (ep2_push) ep2_wp <= ep2_wp + 1'b1;
            if (ep2_pop)  ep2_rp <= ep2_rp + 1'b1;
            if (ep6_push) ep6_wp <= ep6_wp + 1'b1;
            if (ep6_pop)  ep6_rp <= ep6_rp + 1'b1;
            ep2_cnt     <= ep2_cnt_nxt;
            ep6_cnt     <= ep6_cnt_nxt;
            bus.flag_ef <= (ep2_cnt_nxt != '0);
            bus.flag_ff <= (ep6_cnt_nxt != CNT_FULL);
        end
    end

    // Storage needs no reset: clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (ep2_push) ep2_mem[ep2_wp] <= host_wr_data;
        if (ep6_push) ep6_mem[ep6_wp] <= data;
    end

    // Bus drive is purely combinational so turn-around costs no cycles.
    assign data_oe  = clk_locked && !bus.sloe && (bus.addr == 2'b00);
    assign data_out = ep2_empty ? IDLE_WORD : ep2_mem[ep2_rp];
    assign data     = data_oe ? data_out : 16'hzzzz;

    assign host_wr_ready = !ep2_full;
    assign host_rd_valid = clk_locked && !ep6_empty;
    assign host_rd_data  = ep6_mem[ep6_rp];

`ifdef FX2_SLFIFO_ERRCNT_EN
    logic [7:0] err_q;
    logic       err_hit;

    // Any protocol violation in a cycle counts once.
    always_comb begin
        err_hit = 1'b0;
        if (!bus.slrd && (bus.addr == 2'b00) && ep2_empty) err_hit = 1'b1;
        if (!bus.slwr && (bus.addr == 2'b10) && ep6_full)  err_hit = 1'b1;
        if (!bus.slwr && !bus.sloe)                        err_hit = 1'b1;
        if ((!bus.slrd || !bus.slwr) && bus.addr[0])       err_hit = 1'b1;
    end

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (!clk_locked)                    err_q <= 8'h00;
        else if (err_hit && err_q != 8'hFF) err_q <= err_q + 8'h01;
    end

    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_fx2_slave_fifo.sv
// Directed bench for fx2_slave_fifo: host/FPGA traffic on both endpoints with
// queue scoreboards holding the words each FIFO should deliver.
module tb_fx2_slave_fifo;
    localparam logic [15:0] IDLE = 16'hCAFE;
`ifdef FX2_SLFIFO_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clk_locked;
    wire  [15:0] data;
    logic [15:0] tb_data;
    logic        tb_oe;
    logic [15:0] host_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [15:0] host_rd_data;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic [7:0]  err_count;

    assign data = tb_oe ? tb_data : 16'hzzzz;

    fx2_slave_fifo_if bus();

    fx2_slave_fifo #(.DEPTH_LOG2(9), .IDLE_WORD(IDLE)) dut (
        .clk           (clk),
        .clk_locked    (clk_locked),
        .data          (data),
        .bus           (bus.slave),
        .host_wr_data  (host_wr_data),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_rd_data  (host_rd_data),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .err_count     (err_count)
    );

    int total = 0;
    int bad = 0;
    int err_exp = 0;
    logic [15:0] ep2_q[$];
    logic [15:0] ep6_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.addr = 2'b00; bus.slrd = 1'b1; bus.slwr = 1'b1; bus.sloe = 1'b1;
        tb_oe = 1'b0; host_wr_valid = 1'b0; host_rd_ready = 1'b0;
    endtask

    task automatic host_push(input logic [15:0] w);
        host_wr_valid = 1'b1; host_wr_data = w; ep2_q.push_back(w);
        step();
        host_wr_valid = 1'b0;
    endtask

    task automatic fpga_read(input string tag);
        bus.addr = 2'b00; bus.sloe = 1'b0; bus.slrd = 1'b0; bus.slwr = 1'b1;
        #1;
        chk(tag, data, ep2_q.pop_front());
        step();
    endtask

    task automatic fpga_write(input logic [15:0] w);
        bus.addr = 2'b10; bus.sloe = 1'b1; bus.slwr = 1'b0; bus.slrd = 1'b1;
        tb_oe = 1'b1; tb_data = w;
        if (ep6_q.size() < 512) ep6_q.push_back(w);
        else err_exp++;
        step();
    endtask

    task automatic host_pop(input string tag);
        host_rd_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, host_rd_valid, 1);
        chk(tag, host_rd_data, ep6_q.pop_front());
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        idle_bus();
        host_wr_data = 16'h0000; tb_data = 16'h0000; clk_locked = 1'b0;
        // reset held 3 cycles with sloe/addr asking for a drive
        bus.sloe = 1'b0;
        repeat (3) step();
        chk("rst_flag_ef", bus.flag_ef, 0);
        chk("rst_flag_ff", bus.flag_ff, 1);
        chk("rst_data_z", dut.data_oe, 0);
        chk("rst_rd_valid", host_rd_valid, 0);
        chk("rst_wr_ready", host_wr_ready, 1);
        chk("rst_err", err_count, 0);
        clk_locked = 1'b1; bus.sloe = 1'b1;
        step();
        chk("rel_flag_ef", bus.flag_ef, 0);
        chk("rel_flag_ff", bus.flag_ff, 1);
        chk("rel_data_z", dut.data_oe, 0);
        chk("rel_rd_valid", host_rd_valid, 0);

        // error counting: 3 empty reads then one contention cycle
        bus.addr = 2'b00; bus.sloe = 1'b0; bus.slrd = 1'b0;
        repeat (3) begin
            #1;
            chk("err_idle_word", data, IDLE);
            step();
        end
        bus.slrd = 1'b1; bus.slwr = 1'b0;
        step();
        idle_bus();
        chk("err_count_4", err_count, ERRCNT ? 4 : 0);
        chk("err_ef_empty", bus.flag_ef, 0);
        chk("err_no_ep6_write", host_rd_valid, 0);
        clk_locked = 1'b0; step(); step(); clk_locked = 1'b1; step();
        chk("err_cleared", err_count, 0);

        // short read
        host_push(16'h0F01);
        chk("push1_ef", bus.flag_ef, 1);
        host_push(16'h00F2);
        fpga_read("rd_0f01");
        chk("rd1_ef_still", bus.flag_ef, 1);
        fpga_read("rd_00f2");
        bus.slrd = 1'b1;
        chk("rd_ef_fall", bus.flag_ef, 0);
        #1;
        chk("rd_idle_word", data, IDLE);
        bus.sloe = 1'b1;
        #1;
        chk("rd_turnoff", dut.data_oe, 0);

        // short write
        chk("wr_pre_valid", host_rd_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            fpga_write(16'(i));
            if (i == 1) chk("wr_valid_rise", host_rd_valid, 1);
        end
        idle_bus();
        repeat (4) host_pop("pop_short");
        host_rd_ready = 1'b0;
        chk("pop_short_empty", host_rd_valid, 0);

        // full burst through EP2, pointers cross the wrap
        for (int i = 0; i < 512; i++) host_push(16'(i));
        chk("burst_full_ready", host_wr_ready, 0);
        chk("burst_full_ef", bus.flag_ef, 1);
        host_wr_valid = 1'b1; host_wr_data = 16'hDEAD;
        step();
        host_wr_valid = 1'b0;
        for (int i = 0; i < 512; i++) fpga_read("burst_rd");
        bus.slrd = 1'b1;
        chk("burst_drained_ef", bus.flag_ef, 0);
        chk("burst_drained_ready", host_wr_ready, 1);
        for (int i = 0; i < 256; i++) host_push(16'h1000 + 16'(i));
        for (int i = 0; i < 256; i++) fpga_read("wrap_rd");
        idle_bus();

        // simultaneous push/pop on EP6 at count=1
        fpga_write(16'hA001);
        tb_data = 16'hA002; ep6_q.push_back(16'hA002); host_rd_ready = 1'b1;
        #1;
        chk("sim_pop_a001", host_rd_data, ep6_q.pop_front());
        step();
        idle_bus();
        chk("sim_cnt1_valid", host_rd_valid, 1);
        chk("sim_cnt1_ff", bus.flag_ff, 1);
        host_pop("sim_pop_a002");
        host_rd_ready = 1'b0;
        chk("sim_empty", host_rd_valid, 0);

        // EP6 full: lone write dropped, then write+pop drops the write only
        for (int i = 0; i < 512; i++) fpga_write(16'h2000 + 16'(i));
        chk("ep6_full_ff", bus.flag_ff, 0);
        fpga_write(16'hBEEF);
        chk("full_drop_ff", bus.flag_ff, 0);
        tb_data = 16'hBEE0; err_exp++; host_rd_ready = 1'b1;
        #1;
        chk("full_pop_data", host_rd_data, ep6_q.pop_front());
        step();
        idle_bus();
        chk("full_pop_ff", bus.flag_ff, 1);
        repeat (511) host_pop("full_drain");
        host_rd_ready = 1'b0;
        chk("full_drain_empty", host_rd_valid, 0);

        // strobes on EP8/EP4 are ignored and never drive the bus
        host_push(16'h5A5A);
        bus.addr = 2'b11; bus.slrd = 1'b0; bus.slwr = 1'b0; tb_oe = 1'b1; tb_data = 16'h1234;
        #1;
        chk("ep8_no_drive", dut.data_oe, 0);
        step(); err_exp++;
        bus.addr = 2'b01; bus.slwr = 1'b1; bus.sloe = 1'b0; tb_oe = 1'b0;
        #1;
        chk("ep4_no_drive", dut.data_oe, 0);
        step(); err_exp++;
        idle_bus();
        chk("other_ep_ef", bus.flag_ef, 1);
        chk("other_ep_ep6", host_rd_valid, 0);
        fpga_read("other_ep_rd");
        idle_bus();
        chk("err_final", err_count, ERRCNT ? 32'(err_exp) : 32'd0);

        // reset mid-transfer discards stored words
        host_push(16'h7777);
        fpga_write(16'h8888);
        idle_bus();
        chk("pre_rst_ef", bus.flag_ef, 1);
        chk("pre_rst_valid", host_rd_valid, 1);
        clk_locked = 1'b0;
        step();
        chk("mid_rst_ef", bus.flag_ef, 0);
        chk("mid_rst_ff", bus.flag_ff, 1);
        chk("mid_rst_valid", host_rd_valid, 0);
        chk("mid_rst_err", err_count, 0);
        clk_locked = 1'b1;
        step();
        chk("post_rst_ef", bus.flag_ef, 0);
        chk("post_rst_valid", host_rd_valid, 0);
        chk("post_rst_ready", host_wr_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
